// File: rtl/mult_share_arbiter_if.sv
// Operand and result handshake bundle for the two requesters of mult_share_arbiter.
// The arbiter takes the slave side; the requesters take the master side.
interface mult_share_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       rsp0_valid;
    logic       rsp0_ready;
    logic [7:0] rsp0_p;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [7:0] rsp1_p;

    modport slave (
        input  req0_valid, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_p,
        output req1_ready, rsp1_valid, rsp1_p
    );

    modport master (
        output req0_valid, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_p,
        input  req1_ready, rsp1_valid, rsp1_p
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// One 4x4 array multiplier shared round-robin between two valid/ready requesters,
// sequenced IDLE -> CALC -> RESP with per-requester completion counters.

module multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0][7:0] pp;
    logic [4:0][7:0] acc;

    assign acc[0] = '0;
    for (genvar i = 0; i < 4; i++) begin : g_row
        assign pp[i]    = b[i] ? ({4'b0, a} << i) : 8'd0;
        assign acc[i+1] = acc[i] + pp[i];
    end
    assign p = acc[4];
endmodule

// Per-requester handshake gating and completion counter.
module mult_share_arbiter_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic       resp,
    input  logic       win,
    input  logic       own,
    input  logic       req_valid,
    input  logic       rsp_ready,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] done_cnt
);
    assign req_ready = idle & req_valid & win;
    assign rsp_valid = resp & own;

    always_ff @(posedge clk) begin
        if (rst)
            done_cnt <= '0;
        else if (rsp_valid && rsp_ready)
            done_cnt <= done_cnt + 8'd1;
    end
endmodule

module mult_share_arbiter #(
    parameter int DATA_W  = 4,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [7:0]           done0_cnt,
    output logic [7:0]           done1_cnt
);
    localparam int NUM_REQ = 2;
    localparam int P_W     = 2 * DATA_W;

    if (DATA_W != 4) begin : g_bad_width
        $error("mult_share_arbiter: DATA_W must be 4 to match the shared multiplier");
    end

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                           state, state_nxt;
    logic [NUM_REQ-1:0]               req_vld, req_rdy, rsp_rdy, rsp_vld;
    logic [NUM_REQ-1:0]               win_vec, own_vec;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_a, req_b;
    logic [NUM_REQ-1:0][7:0]          done_cnt;
    logic [DATA_W-1:0]                op_a, op_b;
    logic [P_W-1:0]                   prod_reg, mul_p;
    logic                             owner, last_grant, winner, accept;

    assign req_vld = {bus.req1_valid, bus.req0_valid};
    assign req_a   = {bus.req1_a, bus.req0_a};
    assign req_b   = {bus.req1_b, bus.req0_b};
    assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};

    // A lone requester always wins; on a tie the one not granted last time wins.
    always_comb begin
        winner = 1'b0;
        case (req_vld)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && (req_vld != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_rdy[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operands are captured at the handshake so requester changes afterwards cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            owner      <= 1'b0;
            last_grant <= ~RR_INIT;
            prod_reg   <= '0;
        end else begin
            if (accept) begin
                op_a       <= req_a[winner];
                op_b       <= req_b[winner];
                owner      <= winner;
                last_grant <= winner;
            end
            if (state == CALC)
                prod_reg <= mul_p;
        end
    end

    multiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
        assign win_vec[k] = (winner == 1'(k));
        assign own_vec[k] = (owner == 1'(k));

        mult_share_arbiter_port u_port (
            .clk       (clk),
            .rst       (rst),
            .idle      (state == IDLE),
            .resp      (state == RESP),
            .win       (win_vec[k]),
            .own       (own_vec[k]),
            .req_valid (req_vld[k]),
            .rsp_ready (rsp_rdy[k]),
            .req_ready (req_rdy[k]),
            .rsp_valid (rsp_vld[k]),
            .done_cnt  (done_cnt[k])
        );
    end

    assign bus.req0_ready = req_rdy[0];
    assign bus.req1_ready = req_rdy[1];
    assign bus.rsp0_valid = rsp_vld[0];
    assign bus.rsp1_valid = rsp_vld[1];
    assign bus.rsp0_p     = prod_reg;
    assign bus.rsp1_p     = prod_reg;

    assign busy      = (state != IDLE);
    assign done0_cnt = done_cnt[0];
    assign done1_cnt = done_cnt[1];
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized checks of mult_share_arbiter against a transaction-level
// reference model (one pending job, its age, round-robin memory, completion counts).
module tb_mult_share_arbiter;
    localparam bit RR_INIT = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] done0_cnt, done1_cnt;

    mult_share_arbiter_if bus();

    mult_share_arbiter #(.DATA_W(4), .RR_INIT(RR_INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .done0_cnt (done0_cnt),
        .done1_cnt (done1_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int delivered [2] = '{0, 0};

    // Reference model: a job is either absent, computing, or waiting to be returned.
    bit         m_pend = 0;
    bit         m_resp = 0;
    bit         m_own  = 0;
    bit         m_last = 1;
    logic [3:0] m_a = 0, m_b = 0;
    logic [7:0] m_prod = 0;
    logic [7:0] m_cnt [2] = '{8'd0, 8'd0};
    bit         acc0 = 0, acc1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input int k);
        logic mine, other;
        mine  = (k == 0) ? bus.req0_valid : bus.req1_valid;
        other = (k == 0) ? bus.req1_valid : bus.req0_valid;
        if (m_pend || !mine) return 1'b0;
        if (other) return (m_last != k[0]);
        return 1'b1;
    endfunction

    task automatic check_outputs();
        if (!chk_en) return;
        chk("req0_ready", bus.req0_ready, exp_ready(0));
        chk("req1_ready", bus.req1_ready, exp_ready(1));
        chk("rsp0_valid", bus.rsp0_valid, m_pend && m_resp && !m_own);
        chk("rsp1_valid", bus.rsp1_valid, m_pend && m_resp && m_own);
        chk("rsp0_p", bus.rsp0_p, m_prod);
        chk("rsp1_p", bus.rsp1_p, m_prod);
        chk("busy", busy, m_pend);
        chk("done0_cnt", done0_cnt, m_cnt[0]);
        chk("done1_cnt", done1_cnt, m_cnt[1]);
        if (bus.rsp0_valid === 1'b1 && bus.rsp0_ready === 1'b1) delivered[0]++;
        if (bus.rsp1_valid === 1'b1 && bus.rsp1_ready === 1'b1) delivered[1]++;
    endtask

    task automatic model_step();
        logic r0, r1, own_rdy;
        r0 = exp_ready(0);
        r1 = exp_ready(1);
        own_rdy = m_own ? bus.rsp1_ready : bus.rsp0_ready;
        acc0 = 0;
        acc1 = 0;
        if (rst) begin
            m_pend = 0; m_resp = 0; m_own = 0; m_last = ~RR_INIT;
            m_prod = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (m_pend && !m_resp) begin
            m_resp = 1;
            m_prod = 8'(m_a) * 8'(m_b);
        end else if (m_pend) begin
            if (own_rdy === 1'b1) begin
                m_pend = 0;
                m_resp = 0;
                m_cnt[m_own] = m_cnt[m_own] + 8'd1;
            end
        end else if (r0) begin
            m_pend = 1; m_resp = 0; m_own = 0; m_last = 0;
            m_a = bus.req0_a; m_b = bus.req0_b; acc0 = 1;
        end else if (r1) begin
            m_pend = 1; m_resp = 0; m_own = 1; m_last = 1;
            m_a = bus.req1_a; m_b = bus.req1_b; acc1 = 1;
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 ns later.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.rsp0_ready = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.rsp1_ready = 0;
    endtask

    int base, p0, p1, next_idx;
    bit have0, have1;

    initial begin
        rst = 1;
        quiet_inputs();
        @(negedge clk);
        cycle();
        chk_en = 1;
        cycle();
        rst = 0;

        // Single request 7*9.
        bus.req0_valid = 1; bus.req0_a = 4'd7; bus.req0_b = 4'd9; bus.rsp0_ready = 1;
        #1 chk("single_ready", bus.req0_ready, 1'b1);
        cycle();
        bus.req0_valid = 0;
        cycle();
        chk("single_valid", bus.rsp0_valid, 1'b1);
        chk("single_p", bus.rsp0_p, 8'd63);
        cycle();
        chk("single_cnt", done0_cnt, 8'd1);
        cycle();

        // Tie right after reset: RR_INIT wins first, then grants alternate.
        rst = 1; cycle(); rst = 0;
        bus.req0_valid = 1; bus.req0_a = 4'd15; bus.req0_b = 4'd15;
        bus.req1_valid = 1; bus.req1_a = 4'd3;  bus.req1_b = 4'd5;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        #1 chk("tie_first_grant", bus.req0_ready, 1'b1);
        repeat (12) cycle();
        bus.req0_valid = 0; bus.req1_valid = 0;
        for (int n = 0; n < 6 && m_pend; n++) cycle();

        // Backpressure on requester 1 while requester 0 waits.
        bus.req1_valid = 1; bus.req1_a = 4'd12; bus.req1_b = 4'd11; bus.rsp1_ready = 0;
        cycle();
        bus.req1_valid = 0;
        bus.req0_valid = 1; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
        repeat (12) cycle();
        chk("bp_valid", bus.rsp1_valid, 1'b1);
        chk("bp_p", bus.rsp1_p, 8'd132);
        chk("bp_busy", busy, 1'b1);
        chk("bp_req0_blocked", bus.req0_ready, 1'b0);
        bus.rsp1_ready = 1;
        cycle();
        chk("bp_release_idle", busy, 1'b0);
        cycle();
        bus.req0_valid = 0;
        repeat (4) cycle();

        // Reset during CALC discards the job.
        bus.req0_valid = 1; bus.req0_a = 4'd9; bus.req0_b = 4'd9;
        cycle();
        bus.req0_valid = 0;
        rst = 1;
        cycle();
        rst = 0;
        chk("rstcalc_valid", bus.rsp0_valid, 1'b0);
        chk("rstcalc_p", bus.rsp0_p, 8'd0);
        chk("rstcalc_busy", busy, 1'b0);
        chk("rstcalc_cnt", done0_cnt, 8'd0);
        repeat (4) cycle();

        // 256 completions on requester 0 wrap its counter.
        base = delivered[0];
        bus.req0_valid = 1; bus.rsp0_ready = 1;
        bus.req0_a = 4'($urandom_range(0, 15)); bus.req0_b = 4'($urandom_range(0, 15));
        for (int n = 0; n < 1200 && (delivered[0] - base) < 256; n++) begin
            cycle();
            if (acc0) begin
                bus.req0_a = 4'($urandom_range(0, 15));
                bus.req0_b = 4'($urandom_range(0, 15));
            end
        end
        bus.req0_valid = 0;
        chk("wrap_count", delivered[0] - base, 256);
        chk("wrap_done0", done0_cnt, 8'd0);
        chk("wrap_done1", done1_cnt, 8'd0);
        repeat (2) cycle();

        // All 256 operand pairs spread over both requesters with random stalls.
        base = delivered[0] + delivered[1];
        next_idx = 0; have0 = 0; have1 = 0; p0 = 0; p1 = 0;
        for (int n = 0; n < 4000 && (delivered[0] + delivered[1] - base) < 256; n++) begin
            if (!have0 && next_idx < 256) begin p0 = next_idx; next_idx++; have0 = 1; end
            if (!have1 && next_idx < 256) begin p1 = next_idx; next_idx++; have1 = 1; end
            bus.req0_valid = have0 && ($urandom_range(0, 4) != 0);
            bus.req0_a = 4'(p0 >> 4); bus.req0_b = 4'(p0 & 15);
            bus.req1_valid = have1 && ($urandom_range(0, 4) != 0);
            bus.req1_a = 4'(p1 >> 4); bus.req1_b = 4'(p1 & 15);
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc0) have0 = 0;
            if (acc1) have1 = 0;
        end
        chk("exh_delivered", delivered[0] + delivered[1] - base, 256);
        chk("exh_cnt_sum", 8'(done0_cnt + done1_cnt), 8'(m_cnt[0] + m_cnt[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
